pipeline_capture_latch: RTL and testbench

PIPELINE_CAPTURE_LATCH -- requirements
Module: pipeline_capture_latch

---
 rtl/pipeline_capture_latch.sv | 88 ++++++++
 tb/tb_pipeline_capture_latch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_capture_latch.sv
// Memory-stage capture latch: registers control/load data and buffers
// data-cache hits that arrive while the stage is held.
module pipeline_capture_latch #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 64,
   parameter int NCH    = 1,
   parameter int CNT_W  = 16
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  en,
   input  logic                  flush,
   input  logic                  clr_cnt,
   input  logic [CTRL_W-1:0]     in_ctrl,
   input  logic [NCH-1:0]        dhit,
   input  logic [NCH*DATA_W-1:0] dload,
   output logic [CTRL_W-1:0]     out_ctrl,
   output logic [NCH*DATA_W-1:0] out_dload,
   output logic [NCH-1:0]        out_dvalid,
   output logic [NCH-1:0]        cap_full,
   output logic [CNT_W-1:0]      stall_cnt
);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic hold;
   assign hold = !flush && !en;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         out_ctrl <= '0;
      end else if (flush) begin
         out_ctrl <= '0;
      end else if (en) begin
         out_ctrl <= in_ctrl;
      end
   end

   // Saturating count of cycles the stage spent held
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt <= '0;
      end else if (clr_cnt) begin
         stall_cnt <= '0;
      end else if (hold && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [0:0]        state;
      logic [DATA_W-1:0] cap;

      assign cap_full[i] = (state == FULL);

      always_ff @(posedge CLK or negedge nRST) begin
         if (!nRST) begin
            state                      <= EMPTY;
            cap                        <= '0;
            out_dload[i*DATA_W+:DATA_W] <= '0;
            out_dvalid[i]              <= 1'b0;
         end else if (flush) begin
            state                      <= EMPTY;
            cap                        <= '0;
            out_dload[i*DATA_W+:DATA_W] <= '0;
            out_dvalid[i]              <= 1'b0;
         end else if (en) begin
            // A buffered hit takes precedence over a fresh one
            if (state == FULL) begin
               out_dload[i*DATA_W+:DATA_W] <= cap;
               out_dvalid[i]              <= 1'b1;
               state                      <= EMPTY;
            end else if (dhit[i]) begin
               out_dload[i*DATA_W+:DATA_W] <= dload[i*DATA_W+:DATA_W];
               out_dvalid[i]              <= 1'b1;
            end else begin
               out_dload[i*DATA_W+:DATA_W] <= '0;
               out_dvalid[i]              <= 1'b0;
            end
         end else if (dhit[i]) begin
            cap   <= dload[i*DATA_W+:DATA_W];
            state <= FULL;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_capture_latch.sv
// Bench for pipeline_capture_latch: directed scenarios plus random
// traffic against a behavioural model of the capture rules.
module tb_pipeline_capture_latch;

   localparam int DW  = 32;
   localparam int CW  = 64;
   localparam int NC  = 2;
   localparam int NW  = 4;
   localparam int SAT = (1 << NW) - 1;

   logic           CLK = 1'b0;
   logic           nRST;
   logic           en, flush, clr_cnt;
   logic [CW-1:0]  in_ctrl;
   logic [NC-1:0]  dhit;
   logic [NC*DW-1:0] dload;
   logic [CW-1:0]  out_ctrl;
   logic [NC*DW-1:0] out_dload;
   logic [NC-1:0]  out_dvalid;
   logic [NC-1:0]  cap_full;
   logic [NW-1:0]  stall_cnt;

   always #5 CLK = ~CLK;

   pipeline_capture_latch #(
      .DATA_W(DW), .CTRL_W(CW), .NCH(NC), .CNT_W(NW)
   ) dut (
      .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
      .clr_cnt(clr_cnt), .in_ctrl(in_ctrl), .dhit(dhit),
      .dload(dload), .out_ctrl(out_ctrl), .out_dload(out_dload),
      .out_dvalid(out_dvalid), .cap_full(cap_full),
      .stall_cnt(stall_cnt)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Model: a pending hit per channel waits for the next advance
   logic [CW-1:0] m_ctrl;
   bit            m_pend [NC];
   logic [DW-1:0] m_data [NC];
   logic [DW-1:0] m_out  [NC];
   bit            m_dv   [NC];
   int            m_cnt;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   function automatic void m_reset();
      m_ctrl = '0;
      m_cnt  = 0;
      for (int i = 0; i < NC; i++) begin
         m_pend[i] = 0;
         m_data[i] = '0;
         m_out[i]  = '0;
         m_dv[i]   = 0;
      end
   endfunction

   function automatic void m_step();
      if (clr_cnt) m_cnt = 0;
      else if (!en && !flush) m_cnt = (m_cnt < SAT) ? m_cnt + 1 : SAT;
      if (flush) begin
         m_ctrl = '0;
         for (int i = 0; i < NC; i++) begin
            m_pend[i] = 0;
            m_data[i] = '0;
            m_out[i]  = '0;
            m_dv[i]   = 0;
         end
      end else if (en) begin
         m_ctrl = in_ctrl;
         for (int i = 0; i < NC; i++) begin
            if (m_pend[i]) begin
               m_out[i] = m_data[i];
               m_dv[i]  = 1;
               m_pend[i] = 0;
            end else if (dhit[i]) begin
               m_out[i] = dload[i*DW+:DW];
               m_dv[i]  = 1;
            end else begin
               m_out[i] = '0;
               m_dv[i]  = 0;
            end
         end
      end else begin
         for (int i = 0; i < NC; i++)
            if (dhit[i]) begin
               m_data[i] = dload[i*DW+:DW];
               m_pend[i] = 1;
            end
      end
   endfunction

   task automatic check_all(input string tag);
      logic [NC*DW-1:0] ed;
      logic [NC-1:0]    ev, ef;
      for (int i = 0; i < NC; i++) begin
         ed[i*DW+:DW] = m_out[i];
         ev[i] = m_dv[i];
         ef[i] = m_pend[i];
      end
      chk({tag, ".ctrl"},  out_ctrl,   m_ctrl);
      chk({tag, ".dload"}, out_dload,  ed);
      chk({tag, ".dvld"},  64'(out_dvalid), 64'(ev));
      chk({tag, ".full"},  64'(cap_full),   64'(ef));
      chk({tag, ".cnt"},   64'(stall_cnt),  64'(m_cnt));
   endtask

   task automatic drive(input bit e, input bit f, input bit c,
                        input logic [1:0] h, input logic [31:0] d0,
                        input logic [31:0] d1);
      en = e; flush = f; clr_cnt = c; dhit = h;
      dload = {d1, d0};
      in_ctrl = {$urandom, $urandom};
   endtask

   task automatic tick(input string tag);
      @(posedge CLK);
      m_step();
      #1;
      check_all(tag);
   endtask

   task automatic async_reset(input string tag);
      #2 nRST = 1'b0;
      m_reset();
      #1;
      check_all(tag);
      #1 nRST = 1'b1;
   endtask

   initial begin
      nRST = 1'b0;
      drive(0, 0, 0, 2'b00, 0, 0);
      m_reset();
      #12;
      check_all("rst");
      @(negedge CLK);
      nRST = 1'b1;

      // Hit buffered while held, delivered on advance
      drive(0, 0, 0, 2'b00, 0, 0);           tick("h1");
      drive(0, 0, 0, 2'b01, 32'hDEADBEEF, 0); tick("h2");
      drive(0, 0, 0, 2'b00, 0, 0);           tick("h3");
      drive(1, 0, 0, 2'b00, 0, 0);           tick("adv");
      chk("r34.data", 64'(out_dload[31:0]), 64'hDEADBEEF);
      chk("r34.vld",  64'(out_dvalid[0]),  64'h1);
      chk("r34.full", 64'(cap_full),       64'h0);
      chk("r34.cnt",  64'(stall_cnt),      64'h3);

      // Same-cycle bypass
      drive(1, 0, 0, 2'b01, 32'h12345678, 0); tick("byp");
      chk("r35.data", 64'(out_dload[31:0]), 64'h12345678);
      chk("r35.full", 64'(cap_full),       64'h0);

      // Flush discards a buffered hit
      drive(0, 0, 0, 2'b01, 32'hAAAA0000, 0); tick("cap");
      chk("r36.full", 64'(cap_full), 64'h1);
      drive(1, 1, 0, 2'b11, 1, 2);           tick("fl");
      chk("r36.fl",   out_dload,    64'h0);
      chk("r36.ctrl", out_ctrl,     64'h0);
      drive(1, 0, 0, 2'b00, 0, 0);           tick("fl2");
      chk("r36.vld",  64'(out_dvalid), 64'h0);
      chk("r36.data", out_dload,       64'h0);

      // Last hit wins, independent channels
      drive(0, 0, 0, 2'b01, 32'h1, 0);       tick("l1");
      drive(0, 0, 0, 2'b01, 32'h2, 0);       tick("l2");
      drive(0, 0, 0, 2'b10, 0, 32'h3);       tick("l3");
      drive(1, 0, 0, 2'b11, 9, 9);           tick("l4");
      chk("r37.data", out_dload, 64'h00000003_00000002);
      chk("r37.vld",  64'(out_dvalid), 64'h3);

      // Saturation and clear
      drive(0, 0, 1, 2'b00, 0, 0);           tick("clr");
      drive(0, 0, 0, 2'b00, 0, 0);
      repeat (20) tick("sat");
      chk("r38.sat", 64'(stall_cnt), 64'd15);
      drive(0, 0, 1, 2'b00, 0, 0);           tick("clr2");
      chk("r38.clr", 64'(stall_cnt), 64'd0);

      // Async reset while channels are full
      drive(0, 0, 0, 2'b11, 32'h55, 32'h66); tick("f");
      chk("r39.full", 64'(cap_full), 64'h3);
      async_reset("ar");
      chk("r39.afull", 64'(cap_full), 64'h0);
      drive(1, 0, 0, 2'b00, 0, 0);           tick("ar2");
      chk("r39.vld", 64'(out_dvalid), 64'h0);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         drive($urandom_range(9, 0) < 4, $urandom_range(19, 0) == 0,
               $urandom_range(29, 0) == 0, 2'($urandom),
               $urandom, $urandom);
         tick("rnd");
         if ($urandom_range(99, 0) == 0) async_reset("rar");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
